// File: rtl/char_motion_ctrl.sv
// char_motion_ctrl: horizontal motion engine for one player.
// Walks the character left/right on frame ticks with facing-dependent
// forward/back speeds, stops the forward walk at the opponent sprite,
// keeps the character inside the arena walls and runs a multi-tick
// knockback when the character is hit. The vertical position is constant.
module char_motion_ctrl #(
    parameter int XW         = 10,
    parameter int INIT_X     = 40,
    parameter int INIT_Y     = 200,
    parameter int MIN_X      = 40,
    parameter int MAX_X      = 600,
    parameter int CHAR_WIDTH = 128,
    parameter int FACING     = 0,
    parameter int STEP_FWD   = 3,
    parameter int STEP_BACK  = 2,
    parameter int MIN_GAP    = 0,
    parameter int KB_DIST    = 32,
    parameter int KB_STEP    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick,
    input  logic [3:0]    state,
    input  logic [XW-1:0] opp_x,
    input  logic          hit_pulse,
    output logic [XW-1:0] char_x,
    output logic [XW-1:0] char_y,
    output logic          kb_active,
    output logic          at_wall_l,
    output logic          at_wall_r
);

    // Two extra bits give headroom for sums above the arena and a sign bit
    // for differences below zero, so nothing wraps before clamping.
    localparam int AW = XW + 2;
    typedef logic signed [AW-1:0] sval_t;

    localparam sval_t WALL_L    = sval_t'(MIN_X);
    localparam sval_t WALL_R    = sval_t'(MAX_X - CHAR_WIDTH);
    // The wall behind the character (the side away from the opponent).
    localparam sval_t BACK_WALL = (FACING == 0) ? WALL_L : WALL_R;
    localparam sval_t S_FWD     = sval_t'(STEP_FWD);
    localparam sval_t S_BACK    = sval_t'(STEP_BACK);
    localparam sval_t SPAN      = sval_t'(CHAR_WIDTH + MIN_GAP);
    localparam sval_t KB_D      = sval_t'(KB_DIST);
    localparam sval_t KB_S      = sval_t'(KB_STEP);
    localparam sval_t ZERO      = sval_t'(0);

    localparam logic [3:0] ST_LEFT  = 4'd1;
    localparam logic [3:0] ST_RIGHT = 4'd2;

    typedef enum logic {
        S_MOVE  = 1'b0,
        S_KNOCK = 1'b1
    } fsm_t;

    fsm_t          fsm_reg;
    fsm_t          fsm_next;
    logic [XW-1:0] x_reg;
    logic [XW-1:0] x_next;
    sval_t         kb_cnt_reg;
    sval_t         kb_cnt_next;

    sval_t x_ext;
    sval_t opp_ext;
    sval_t fwd_limit;
    sval_t fwd_x;
    sval_t back_x;
    sval_t walk_x;
    sval_t kb_remaining;
    sval_t kb_step;
    sval_t kb_x;
    logic  kb_done;
    logic  go_fwd;
    logic  go_back;

    // Keep a position inside the legal arena span.
    function automatic sval_t wall_clamp(input sval_t v);
        sval_t r;
        r = v;
        if (r < WALL_L) begin
            r = WALL_L;
        end else if (r > WALL_R) begin
            r = WALL_R;
        end
        return r;
    endfunction

    // Zero-extend the coordinates into the signed working width.
    always_comb begin
        x_ext   = sval_t'({2'b00, x_reg});
        opp_ext = sval_t'({2'b00, opp_x});
    end

    // Forward limit: closest position that still leaves MIN_GAP to the opponent.
    always_comb begin
        if (FACING == 0) begin
            fwd_limit = opp_ext - SPAN;
            if (fwd_limit < ZERO) begin
                fwd_limit = WALL_L;
            end
        end else begin
            fwd_limit = opp_ext + SPAN;
        end
    end

    // Forward walk: step toward the opponent, never past the limit; an
    // already-overlapping character simply holds instead of being pushed back.
    always_comb begin
        fwd_x = x_ext;
        if (FACING == 0) begin
            if (x_ext < fwd_limit) begin
                fwd_x = x_ext + S_FWD;
                if (fwd_x > fwd_limit) begin
                    fwd_x = fwd_limit;
                end
                fwd_x = wall_clamp(fwd_x);
            end
        end else begin
            if (x_ext > fwd_limit) begin
                fwd_x = x_ext - S_FWD;
                if (fwd_x < fwd_limit) begin
                    fwd_x = fwd_limit;
                end
                fwd_x = wall_clamp(fwd_x);
            end
        end
    end

    // Backward walk: away from the opponent, limited only by the walls.
    always_comb begin
        if (FACING == 0) begin
            back_x = wall_clamp(x_ext - S_BACK);
        end else begin
            back_x = wall_clamp(x_ext + S_BACK);
        end
    end

    // Map the LEFT/RIGHT commands onto forward/back for this side of the arena.
    always_comb begin
        if (FACING == 0) begin
            go_fwd  = (state == ST_RIGHT);
            go_back = (state == ST_LEFT);
        end else begin
            go_fwd  = (state == ST_LEFT);
            go_back = (state == ST_RIGHT);
        end
        if (go_fwd) begin
            walk_x = fwd_x;
        end else if (go_back) begin
            walk_x = back_x;
        end else begin
            walk_x = x_ext;
        end
    end

    // Knockback step: the last step is shortened so the total equals KB_DIST.
    always_comb begin
        kb_remaining = KB_D - kb_cnt_reg;
        kb_step      = (kb_remaining < KB_S) ? kb_remaining : KB_S;
        if (FACING == 0) begin
            kb_x = wall_clamp(x_ext - kb_step);
        end else begin
            kb_x = wall_clamp(x_ext + kb_step);
        end
        kb_done = ((kb_cnt_reg + kb_step) >= KB_D) || (kb_x == BACK_WALL);
    end

    // State register plus position and knockback counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg    <= S_MOVE;
            x_reg      <= XW'(INIT_X);
            kb_cnt_reg <= ZERO;
        end else begin
            fsm_reg    <= fsm_next;
            x_reg      <= x_next;
            kb_cnt_reg <= kb_cnt_next;
        end
    end

    // Next-state: a hit always (re)enters knockback; knockback ends on the
    // tick that completes the distance or lands on the back wall.
    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            S_MOVE: begin
                if (hit_pulse) begin
                    fsm_next = S_KNOCK;
                end
            end
            S_KNOCK: begin
                if (!hit_pulse && frame_tick && kb_done) begin
                    fsm_next = S_MOVE;
                end
            end
            default: fsm_next = S_MOVE;
        endcase
    end

    // Datapath updates: motion only on ticks, and never on a hit edge.
    always_comb begin
        x_next      = x_reg;
        kb_cnt_next = kb_cnt_reg;
        case (fsm_reg)
            S_MOVE: begin
                if (hit_pulse) begin
                    kb_cnt_next = ZERO;
                end else if (frame_tick) begin
                    x_next = XW'(walk_x);
                end
            end
            S_KNOCK: begin
                if (hit_pulse) begin
                    kb_cnt_next = ZERO;
                end else if (frame_tick) begin
                    x_next      = XW'(kb_x);
                    kb_cnt_next = kb_cnt_reg + kb_step;
                end
            end
            default: begin
                x_next      = x_reg;
                kb_cnt_next = kb_cnt_reg;
            end
        endcase
    end

    // Outputs: registered position/mode, wall flags decoded from the position.
    always_comb begin
        char_x    = x_reg;
        char_y    = XW'(INIT_Y);
        kb_active = (fsm_reg == S_KNOCK);
        at_wall_l = (x_ext == WALL_L);
        at_wall_r = (x_ext == WALL_R);
    end

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Testbench for char_motion_ctrl: three instances (default, MIN_GAP=4,
// FACING=1) share stimulus; each is tracked by an integer reference model.
module tb_char_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic [3:0] state;
    logic [9:0] opp_x;
    logic       hit_pulse;

    logic [9:0] dx  [3];
    logic [9:0] dy  [3];
    logic       dkb [3];
    logic       dwl [3];
    logic       dwr [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    char_motion_ctrl u0 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .state(state),
        .opp_x(opp_x), .hit_pulse(hit_pulse),
        .char_x(dx[0]), .char_y(dy[0]), .kb_active(dkb[0]),
        .at_wall_l(dwl[0]), .at_wall_r(dwr[0])
    );

    char_motion_ctrl #(.MIN_GAP(4)) u1 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .state(state),
        .opp_x(opp_x), .hit_pulse(hit_pulse),
        .char_x(dx[1]), .char_y(dy[1]), .kb_active(dkb[1]),
        .at_wall_l(dwl[1]), .at_wall_r(dwr[1])
    );

    char_motion_ctrl #(.FACING(1)) u2 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .state(state),
        .opp_x(opp_x), .hit_pulse(hit_pulse),
        .char_x(dx[2]), .char_y(dy[2]), .kb_active(dkb[2]),
        .at_wall_l(dwl[2]), .at_wall_r(dwr[2])
    );

    // ---------------- reference model ----------------
    localparam int LO = 40;
    localparam int HI = 600 - 128;

    int m_x   [3];
    int m_cnt [3];
    bit m_kb  [3];
    int fac   [3] = '{0, 0, 1};
    int gap   [3] = '{0, 4, 0};

    function automatic int clampw(input int v);
        if (v < LO) return LO;
        if (v > HI) return HI;
        return v;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_edge(input bit r, input bit t, input int st,
                              input int o, input bit h);
        for (int i = 0; i < 3; i++) begin
            int toward;   // +1 or -1: direction of the opponent
            int lim;
            int room;
            int s;
            int nx;
            toward = (fac[i] == 0) ? 1 : -1;
            if (r) begin
                m_x[i] = 40; m_kb[i] = 0; m_cnt[i] = 0;
            end else if (m_kb[i]) begin
                if (h) begin
                    m_cnt[i] = 0;
                end else if (t) begin
                    s  = imin(4, 32 - m_cnt[i]);
                    nx = clampw(m_x[i] - toward * s);
                    m_cnt[i] += s;
                    if (m_cnt[i] >= 32 || nx == ((fac[i] == 0) ? LO : HI)) m_kb[i] = 0;
                    m_x[i] = nx;
                end
            end else if (h) begin
                m_kb[i] = 1; m_cnt[i] = 0;
            end else if (t) begin
                if ((fac[i] == 0 && st == 2) || (fac[i] == 1 && st == 1)) begin
                    if (fac[i] == 0) begin
                        lim = o - 128 - gap[i];
                        if (lim < 0) lim = LO;
                        room = lim - m_x[i];
                    end else begin
                        lim = o + 128 + gap[i];
                        room = m_x[i] - lim;
                    end
                    if (room > 0) m_x[i] = clampw(m_x[i] + toward * imin(3, room));
                end else if ((fac[i] == 0 && st == 1) || (fac[i] == 1 && st == 2)) begin
                    m_x[i] = clampw(m_x[i] - toward * 2);
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one clock's worth of inputs, advance the model, compare all outputs.
    task automatic step(input bit r, input bit t, input int st, input int o, input bit h);
        rst        = r;
        frame_tick = t;
        state      = 4'(st);
        opp_x      = 10'(o);
        hit_pulse  = h;
        model_edge(r, t, st, o, h);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_x", i),  int'(dx[i]),  m_x[i]);
            chk($sformatf("u%0d_kb", i), int'(dkb[i]), int'(m_kb[i]));
            chk($sformatf("u%0d_wl", i), int'(dwl[i]), (m_x[i] == LO) ? 1 : 0);
            chk($sformatf("u%0d_wr", i), int'(dwr[i]), (m_x[i] == HI) ? 1 : 0);
            chk($sformatf("u%0d_y", i),  int'(dy[i]),  200);
        end
    endtask

    // ---------------- directed vector table (instance u0) ----------------
    typedef struct {
        bit t;
        int st;
        int opp;
        bit hit;
        int reps;
        int ex;
        bit ekb;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl [NV];

    initial begin
        int o;
        int sel;
        tbl[0]  = '{1, 1, 600, 0,   3,  40, 0};  // LEFT at wall: no underflow
        tbl[1]  = '{1, 2, 600, 0,   1,  43, 0};
        tbl[2]  = '{1, 1, 600, 0,   1,  41, 0};
        tbl[3]  = '{1, 1, 600, 0,   1,  40, 0};  // 41 -> 40 clamped
        tbl[4]  = '{1, 2, 600, 0, 144, 472, 0};
        tbl[5]  = '{1, 1, 600, 0,   1, 470, 0};
        tbl[6]  = '{1, 2, 600, 0,   1, 472, 0};  // right wall clamp
        tbl[7]  = '{1, 2, 600, 0,   1, 472, 0};
        tbl[8]  = '{0, 2, 600, 0,  10, 472, 0};  // no tick: hold
        tbl[9]  = '{1, 1, 600, 0, 186, 100, 0};
        tbl[10] = '{1, 2, 230, 0,   1, 102, 0};  // collision limit
        tbl[11] = '{1, 2, 230, 0,   1, 102, 0};
        tbl[12] = '{1, 2, 600, 0,  34, 204, 0};
        tbl[13] = '{1, 1, 600, 0,   2, 200, 0};
        tbl[14] = '{0, 0, 600, 1,   1, 200, 1};  // hit
        tbl[15] = '{1, 2, 600, 0,   7, 172, 1};
        tbl[16] = '{1, 2, 600, 0,   1, 168, 0};  // distance complete
        tbl[17] = '{1, 2, 600, 0,   1, 171, 0};
        tbl[18] = '{1, 2, 600, 0,   1, 174, 0};
        tbl[19] = '{1, 1, 600, 0,  62,  50, 0};
        tbl[20] = '{0, 0, 600, 1,   1,  50, 1};
        tbl[21] = '{1, 0, 600, 0,   1,  46, 1};
        tbl[22] = '{1, 0, 600, 0,   1,  42, 1};
        tbl[23] = '{1, 0, 600, 0,   1,  40, 0};  // wall ends knockback
        tbl[24] = '{1, 2, 600, 0,  28, 124, 0};
        tbl[25] = '{0, 0, 600, 1,   1, 124, 1};
        tbl[26] = '{1, 0, 600, 0,   2, 116, 1};
        tbl[27] = '{1, 0, 600, 1,   1, 116, 1};  // re-hit: restart, no motion
        tbl[28] = '{1, 0, 600, 0,   7,  88, 1};
        tbl[29] = '{1, 0, 600, 0,   1,  84, 0};
        tbl[30] = '{1, 2, 600, 1,   1,  84, 1};  // hit with tick: no move
        tbl[31] = '{1, 9, 600, 0,   1,  80, 1};  // state ignored in knockback

        rst = 1'b1; frame_tick = 1'b0; state = 4'd0; opp_x = 10'd600; hit_pulse = 1'b0;

        // Reset state, with hit asserted to show reset wins.
        step(1, 1, 2, 600, 1);
        chk("rst_x", int'(dx[0]), 40);
        chk("rst_kb", int'(dkb[0]), 0);
        chk("rst_wl", int'(dwl[0]), 1);
        $display("reset: x=%0d y=%0d kb=%0d", dx[0], dy[0], dkb[0]);

        for (int i = 0; i < NV; i++) begin
            repeat (tbl[i].reps) step(0, tbl[i].t, tbl[i].st, tbl[i].opp, tbl[i].hit);
            chk($sformatf("row%0d_x", i),  int'(dx[0]),  tbl[i].ex);
            chk($sformatf("row%0d_kb", i), int'(dkb[0]), int'(tbl[i].ekb));
            $display("row %0d: x=%0d kb=%0d", i, dx[0], dkb[0]);
        end

        // Reset in the middle of a knockback.
        step(1, 1, 2, 600, 1);
        chk("rst_mid_kb_x", int'(dx[0]), 40);
        chk("rst_mid_kb_kb", int'(dkb[0]), 0);
        $display("reset mid-knockback: x=%0d kb=%0d", dx[0], dkb[0]);

        // Minimum gap: overlap holds instead of pushing back.
        repeat (20) step(0, 1, 2, 600, 0);
        step(0, 1, 2, 230, 0);
        chk("gap0_x", int'(dx[0]), 102);
        chk("gap4_x", int'(dx[1]), 100);
        $display("gap: u0 x=%0d u1 x=%0d", dx[0], dx[1]);

        // FACING=1: forward is -x, knockback goes +x.
        step(1, 0, 0, 40, 0);
        repeat (130) step(0, 1, 2, 40, 0);
        chk("f1_walk_x", int'(dx[2]), 300);
        step(0, 1, 1, 40, 0);
        chk("f1_fwd_x", int'(dx[2]), 297);
        step(0, 1, 2, 40, 0);
        chk("f1_back_x", int'(dx[2]), 299);
        step(0, 0, 0, 40, 1);
        chk("f1_hit_kb", int'(dkb[2]), 1);
        step(0, 1, 0, 40, 0);
        step(0, 1, 0, 40, 0);
        chk("f1_kb_x", int'(dx[2]), 307);
        step(1, 1, 0, 40, 0);
        chk("f1_rst_x", int'(dx[2]), 40);
        chk("f1_rst_kb", int'(dkb[2]), 0);
        $display("facing1: x=%0d kb=%0d", dx[2], dkb[2]);

        // Randomized traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            sel = int'($urandom_range(0, 2));
            if (sel == 0) begin
                o = int'($urandom_range(0, 1023));
            end else if (sel == 1) begin
                o = m_x[0] + 128 + int'($urandom_range(0, 12));
            end else begin
                o = m_x[2] - 128 - int'($urandom_range(0, 12));
            end
            if (o < 0) o = 0;
            if (o > 1023) o = 1023;
            step(($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                             : int'($urandom_range(1, 2)),
                 o,
                 ($urandom_range(0, 19) == 0));
        end
        $display("random: 2500 cycles done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
